// File: rtl/disp_arb_pkg.sv
// Shared encodings and helpers for the seven-segment display arbiter.
// Source codes double as the FSM state encoding so active_src is a direct copy.
package disp_arb_pkg;

    typedef enum logic [1:0] {
        SHOW_BG = 2'd0,
        SHOW_M1 = 2'd1,
        SHOW_M2 = 2'd2
    } state_t;

    localparam logic [1:0] SRC_BG = 2'd0;
    localparam logic [1:0] SRC_M1 = 2'd1;
    localparam logic [1:0] SRC_M2 = 2'd2;

    function automatic logic [15:0] blank_word(input logic [3:0] nib);
        return {4{nib}};
    endfunction

endpackage

// File: rtl/msg_timer.sv
// Message display timer and blink phase generator; expire is the current-cycle view,
// phase_on is the phase that will be in effect next cycle so the caller can register it.
module msg_timer #(
    parameter int MSG_CYCLES   = 100_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic blink_en,
    output logic expire,
    output logic phase_on
);

    localparam int TW = ($clog2(MSG_CYCLES) < 1) ? 1 : $clog2(MSG_CYCLES);
    localparam int BW = ($clog2(BLINK_CYCLES) < 1) ? 1 : $clog2(BLINK_CYCLES);
    localparam logic [TW-1:0] TMR_LOAD   = TW'(MSG_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic [TW-1:0] tmr_q, tmr_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        tmr_d = tmr_q;
        if (load) begin
            tmr_d = TMR_LOAD;
        end else if (tmr_q != '0) begin
            tmr_d = tmr_q - TW'(1);
        end
    end

    // A fresh message always starts in the visible phase.
    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (load || !blink_en) begin
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (bcnt_q == BLINK_LAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d  = bcnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else begin
            tmr_q   <= tmr_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign expire   = (tmr_q == '0);
    assign phase_on = phase_d;

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates the seven-segment digit bus between background, low- and high-priority messages.
// One cycle input-to-output latency; no backpressure, a second M1 while M2 shows overwrites the pending slot.
module display_arbiter
    import disp_arb_pkg::*;
#(
    parameter int         MSG_CYCLES   = 100_000_000,
    parameter int         BLINK_CYCLES = 12_500_000,
    parameter logic [3:0] BLANK_NIBBLE = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bg_digits,
    input  logic        m1_valid,
    input  logic [15:0] m1_digits,
    input  logic        m1_blink,
    input  logic        m2_valid,
    input  logic [15:0] m2_digits,
    input  logic        m2_blink,
    input  logic        clear_msgs,
    output logic [15:0] digits,
    output logic [1:0]  active_src,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [15:0] msg_q, msg_d;
    logic        blink_q, blink_d;
    logic        pend_vld_q, pend_vld_d;
    logic [15:0] pend_dat_q, pend_dat_d;
    logic        pend_blk_q, pend_blk_d;
    logic [15:0] digits_q, digits_d;
    logic [1:0]  src_q, src_d;
    logic        busy_q, busy_d;

    logic load;
    logic expire;
    logic phase_on;

    msg_timer #(
        .MSG_CYCLES   (MSG_CYCLES),
        .BLINK_CYCLES (BLINK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .blink_en (blink_q),
        .expire   (expire),
        .phase_on (phase_on)
    );

    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        blink_d    = blink_q;
        pend_vld_d = pend_vld_q;
        pend_dat_d = pend_dat_q;
        pend_blk_d = pend_blk_q;
        load       = 1'b0;
        if (clear_msgs) begin
            state_d    = SHOW_BG;
            pend_vld_d = 1'b0;
        end else begin
            case (state_q)
                SHOW_BG, SHOW_M1: begin
                    if (m2_valid) begin
                        state_d = SHOW_M2;
                        msg_d   = m2_digits;
                        blink_d = m2_blink;
                        load    = 1'b1;
                        if (m1_valid) begin
                            pend_vld_d = 1'b1;
                            pend_dat_d = m1_digits;
                            pend_blk_d = m1_blink;
                        end
                    end else if (m1_valid) begin
                        state_d = SHOW_M1;
                        msg_d   = m1_digits;
                        blink_d = m1_blink;
                        load    = 1'b1;
                    end else if (state_q == SHOW_M1 && expire) begin
                        state_d = SHOW_BG;
                    end
                end
                SHOW_M2: begin
                    if (m1_valid) begin
                        pend_vld_d = 1'b1;
                        pend_dat_d = m1_digits;
                        pend_blk_d = m1_blink;
                    end
                    if (m2_valid) begin
                        msg_d   = m2_digits;
                        blink_d = m2_blink;
                        load    = 1'b1;
                    end else if (expire) begin
                        // An M1 arriving on the expiry cycle is the newest pending entry.
                        if (m1_valid || pend_vld_q) begin
                            state_d    = SHOW_M1;
                            msg_d      = m1_valid ? m1_digits : pend_dat_q;
                            blink_d    = m1_valid ? m1_blink : pend_blk_q;
                            load       = 1'b1;
                            pend_vld_d = 1'b0;
                        end else begin
                            state_d = SHOW_BG;
                        end
                    end
                end
                default: state_d = SHOW_BG;
            endcase
        end
    end

    always_comb begin
        case (state_d)
            SHOW_M1: src_d = SRC_M1;
            SHOW_M2: src_d = SRC_M2;
            default: src_d = SRC_BG;
        endcase
        if (state_d == SHOW_BG) begin
            digits_d = bg_digits;
        end else if (blink_d && !phase_on) begin
            digits_d = blank_word(BLANK_NIBBLE);
        end else begin
            digits_d = msg_d;
        end
        busy_d = (state_d != SHOW_BG) | pend_vld_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SHOW_BG;
            msg_q      <= '0;
            blink_q    <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_dat_q <= '0;
            pend_blk_q <= 1'b0;
            digits_q   <= blank_word(BLANK_NIBBLE);
            src_q      <= SRC_BG;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            msg_q      <= msg_d;
            blink_q    <= blink_d;
            pend_vld_q <= pend_vld_d;
            pend_dat_q <= pend_dat_d;
            pend_blk_q <= pend_blk_d;
            digits_q   <= digits_d;
            src_q      <= src_d;
            busy_q     <= busy_d;
        end
    end

    assign digits     = digits_q;
    assign active_src = src_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: message-level reference model checked every cycle plus directed literal sequences.
module tb_display_arbiter;

    localparam int MSG   = 8;
    localparam int BLINK = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] bg_digits = 16'h1234;
    logic        m1_valid = 1'b0;
    logic [15:0] m1_digits = '0;
    logic        m1_blink = 1'b0;
    logic        m2_valid = 1'b0;
    logic [15:0] m2_digits = '0;
    logic        m2_blink = 1'b0;
    logic        clear_msgs = 1'b0;
    logic [15:0] digits;
    logic [1:0]  active_src;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    display_arbiter #(
        .MSG_CYCLES   (MSG),
        .BLINK_CYCLES (BLINK),
        .BLANK_NIBBLE (4'hF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bg_digits  (bg_digits),
        .m1_valid   (m1_valid),
        .m1_digits  (m1_digits),
        .m1_blink   (m1_blink),
        .m2_valid   (m2_valid),
        .m2_digits  (m2_digits),
        .m2_blink   (m2_blink),
        .clear_msgs (clear_msgs),
        .digits     (digits),
        .active_src (active_src),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: which message is on screen and how many cycles it has been shown.
    int          m_src;
    logic [15:0] m_msg;
    bit          m_blk;
    int          m_age;
    bit          m_pv;
    logic [15:0] m_pd;
    bit          m_pb;
    logic [15:0] exp_digits;
    logic [1:0]  exp_src;
    bit          exp_busy;

    task automatic m_start(input int s, input logic [15:0] d, input bit b);
        m_src = s;
        m_msg = d;
        m_blk = b;
        m_age = 0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_src      = 0;
            m_pv       = 0;
            m_age      = 0;
            exp_digits = 16'hFFFF;
            exp_src    = 2'd0;
            exp_busy   = 0;
        end else begin
            if (clear_msgs) begin
                m_src = 0;
                m_pv  = 0;
            end else if (m_src == 0 || m_src == 1) begin
                if (m2_valid) begin
                    m_start(2, m2_digits, m2_blink);
                    if (m1_valid) begin
                        m_pv = 1; m_pd = m1_digits; m_pb = m1_blink;
                    end
                end else if (m1_valid) begin
                    m_start(1, m1_digits, m1_blink);
                end else if (m_src == 1) begin
                    if (m_age == MSG - 1) m_src = 0;
                    else m_age++;
                end
            end else begin
                if (m1_valid) begin
                    m_pv = 1; m_pd = m1_digits; m_pb = m1_blink;
                end
                if (m2_valid) begin
                    m_start(2, m2_digits, m2_blink);
                end else if (m_age == MSG - 1) begin
                    if (m_pv) begin
                        m_start(1, m_pd, m_pb);
                        m_pv = 0;
                    end else begin
                        m_src = 0;
                    end
                end else begin
                    m_age++;
                end
            end
            exp_src  = 2'(m_src);
            exp_busy = (m_src != 0) || m_pv;
            if (m_src == 0)                                  exp_digits = bg_digits;
            else if (m_blk && ((m_age / BLINK) % 2 == 1))    exp_digits = 16'hFFFF;
            else                                             exp_digits = m_msg;
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            check("model_digits", digits, exp_digits);
            check("model_src", {14'b0, active_src}, {14'b0, exp_src});
            check("model_busy", {15'b0, busy}, {15'b0, exp_busy});
        end
    end

    task automatic watch(input string tag, input int n, input logic [15:0] d,
                         input logic [1:0] s, input bit b);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            m1_valid   = 1'b0;
            m2_valid   = 1'b0;
            clear_msgs = 1'b0;
            check({tag, "_digits"}, digits, d);
            check({tag, "_src"}, {14'b0, active_src}, {14'b0, s});
            check({tag, "_busy"}, {15'b0, busy}, {15'b0, b});
        end
    endtask

    task automatic send_m1(input logic [15:0] d, input bit b);
        m1_valid = 1'b1; m1_digits = d; m1_blink = b;
    endtask

    task automatic send_m2(input logic [15:0] d, input bit b);
        m2_valid = 1'b1; m2_digits = d; m2_blink = b;
    endtask

    initial begin
        #1 reset = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        watch("post_reset", 1, 16'h1234, 2'd0, 1'b0);

        send_m2(16'h0BAD, 1'b0);
        watch("pre_reset_m2", 3, 16'h0BAD, 2'd2, 1'b1);
        reset = 1'b1;
        #1;
        check("in_reset_digits", digits, 16'hFFFF);
        check("in_reset_src", {14'b0, active_src}, 16'h0000);
        check("in_reset_busy", {15'b0, busy}, 16'h0000);
        @(negedge clk);
        check("held_reset_digits", digits, 16'hFFFF);
        reset = 1'b0;
        watch("after_reset", 1, 16'h1234, 2'd0, 1'b0);

        send_m1(16'h0AEB, 1'b0);
        watch("m1", 8, 16'h0AEB, 2'd1, 1'b1);
        watch("m1_end", 1, 16'h1234, 2'd0, 1'b0);

        send_m1(16'h0C1D, 1'b0);
        watch("pre_m1", 3, 16'h0C1D, 2'd1, 1'b1);
        send_m2(16'hEEEE, 1'b0);
        watch("pre_m2", 8, 16'hEEEE, 2'd2, 1'b1);
        watch("pre_end", 3, 16'h1234, 2'd0, 1'b0);

        send_m2(16'h3333, 1'b0);
        watch("pend_m2a", 2, 16'h3333, 2'd2, 1'b1);
        send_m1(16'h1111, 1'b0);
        watch("pend_m2b", 1, 16'h3333, 2'd2, 1'b1);
        send_m1(16'h2222, 1'b0);
        watch("pend_m2c", 5, 16'h3333, 2'd2, 1'b1);
        watch("pend_m1", 8, 16'h2222, 2'd1, 1'b1);
        watch("pend_end", 1, 16'h1234, 2'd0, 1'b0);

        send_m2(16'h5555, 1'b1);
        watch("blink_on1", 2, 16'h5555, 2'd2, 1'b1);
        watch("blink_off1", 2, 16'hFFFF, 2'd2, 1'b1);
        watch("blink_on2", 2, 16'h5555, 2'd2, 1'b1);
        watch("blink_off2", 2, 16'hFFFF, 2'd2, 1'b1);
        watch("blink_end", 1, 16'h1234, 2'd0, 1'b0);

        send_m1(16'hAAAA, 1'b0);
        watch("reload_a", 4, 16'hAAAA, 2'd1, 1'b1);
        send_m1(16'hBBBB, 1'b0);
        watch("reload_b", 8, 16'hBBBB, 2'd1, 1'b1);
        watch("reload_end", 1, 16'h1234, 2'd0, 1'b0);

        send_m2(16'hCCCC, 1'b0);
        watch("exp_m2", 8, 16'hCCCC, 2'd2, 1'b1);
        send_m1(16'hDDDD, 1'b0);
        watch("exp_m1", 8, 16'hDDDD, 2'd1, 1'b1);
        watch("exp_end", 1, 16'h1234, 2'd0, 1'b0);

        send_m2(16'h3333, 1'b0);
        watch("clr_a_m2", 1, 16'h3333, 2'd2, 1'b1);
        send_m1(16'h4444, 1'b0);
        watch("clr_a_pend", 1, 16'h3333, 2'd2, 1'b1);
        clear_msgs = 1'b1;
        send_m2(16'h6666, 1'b0);
        watch("clr_a", 3, 16'h1234, 2'd0, 1'b0);

        send_m1(16'h7777, 1'b0);
        watch("clr_b_m1", 2, 16'h7777, 2'd1, 1'b1);
        clear_msgs = 1'b1;
        send_m2(16'h6666, 1'b0);
        send_m1(16'h8888, 1'b0);
        watch("clr_b", 2, 16'h1234, 2'd0, 1'b0);

        bg_digits = 16'h9876;
        watch("bg_change", 1, 16'h9876, 2'd0, 1'b0);

        send_m2(16'h2A2A, 1'b0);
        send_m1(16'h3B3B, 1'b0);
        watch("both_m2", 8, 16'h2A2A, 2'd2, 1'b1);
        watch("both_m1", 8, 16'h3B3B, 2'd1, 1'b1);
        watch("both_end", 1, 16'h9876, 2'd0, 1'b0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
